// File: rtl/fir_symmetric_param.sv
// Pipelined symmetric-coefficient FIR with streamed coefficient load and valid tagging.
// Optional output saturation when FIR_SAT_EN is defined (otherwise the output wraps).
module fir_symmetric_param #(
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int NTAPS = 7,
    parameter int OW    = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] x_in,
    input  logic          x_valid,
    input  logic [CW-1:0] coef_val,
    input  logic          writeen,
    input  logic          tlast,
    output logic [OW-1:0] y_out,
    output logic          y_valid,
    output logic          coeffs_ready,
    output logic          coef_err
);

    localparam int NU = (NTAPS + 1) / 2;
    localparam int PW = DW + 1;
    localparam int MW = PW + CW;
    localparam int FW = MW + $clog2(NU);
    localparam int IW = $clog2(NU + 1);
    localparam logic [IW-1:0] NU_I   = IW'(NU);
    localparam logic [IW-1:0] LAST_I = IW'(NU - 1);

    logic [IW-1:0] idx;
    logic [CW-1:0] coeffs [NU];
    logic [DW-1:0] taps   [NTAPS];
    logic [PW-1:0] pre    [NU];
    logic [MW-1:0] prod   [NU];
    logic          tag0, tag1, tag2;
    logic [FW-1:0] sum;
    logic [OW-1:0] y_next;

    // A frame is good only if tlast arrives on exactly the NU-th word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx          <= '0;
            coeffs_ready <= 1'b0;
            coef_err     <= 1'b0;
        end else begin
            coef_err <= 1'b0;
            if (writeen) begin
                if (idx == '0) begin
                    coeffs_ready <= 1'b0;
                end
                if (tlast) begin
                    idx <= '0;
                    if (idx == LAST_I) begin
                        coeffs_ready <= 1'b1;
                    end else begin
                        coeffs_ready <= 1'b0;
                        coef_err     <= 1'b1;
                    end
                end else if (idx != NU_I) begin
                    idx <= idx + IW'(1);
                end
            end
        end
    end

    // Coefficient storage deliberately survives reset.
    always_ff @(posedge clk) begin
        if (writeen) begin
            for (int k = 0; k < NU; k++) begin
                if (idx == IW'(k)) begin
                    coeffs[k] <= coef_val;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                taps[k] <= '0;
            end
        end else if (x_valid) begin
            taps[0] <= x_in;
            for (int k = 1; k < NTAPS; k++) begin
                taps[k] <= taps[k-1];
            end
        end
    end

    // Pre-add, multiply and tag stages; the tag is qualified where coeffs are read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag0 <= 1'b0;
            tag1 <= 1'b0;
            tag2 <= 1'b0;
            for (int k = 0; k < NU; k++) begin
                pre[k]  <= '0;
                prod[k] <= '0;
            end
        end else begin
            tag0 <= x_valid;
            tag1 <= tag0;
            tag2 <= tag1 & coeffs_ready;
            for (int k = 0; k < NU; k++) begin
                if (2 * k + 1 == NTAPS) begin
                    pre[k] <= {1'b0, taps[k]};
                end else begin
                    pre[k] <= {1'b0, taps[k]} + {1'b0, taps[NTAPS-1-k]};
                end
                prod[k] <= MW'(coeffs[k]) * MW'(pre[k]);
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < NU; k++) begin
            sum = sum + FW'(prod[k]);
        end
    end

    generate
        if (FW > OW) begin : g_narrow
`ifdef FIR_SAT_EN
            assign y_next = (|sum[FW-1:OW]) ? {OW{1'b1}} : sum[OW-1:0];
`else
            assign y_next = OW'(sum);
`endif
        end else begin : g_wide
            assign y_next = OW'(sum);
        end
    endgenerate

    // Untagged results leave y_out holding its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_out   <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= tag2;
            if (tag2) begin
                y_out <= y_next;
            end
        end
    end

endmodule

// File: tb/tb_fir_symmetric_param.sv
// Directed bench for fir_symmetric_param: 7-tap, 6-tap and narrow-output (OW=12) instances.
module tb_fir_symmetric_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] x_in = '0;
    logic       x_valid = 1'b0;
    logic [7:0] coef_val = '0;
    logic       tlast = 1'b0;
    logic       we7 = 1'b0;
    logic       we6 = 1'b0;
    logic       wew = 1'b0;

    logic [18:0] y7_out;
    logic        y7_valid, y7_ready, y7_err;
    logic [18:0] y6_out;
    logic        y6_valid, y6_ready, y6_err;
    logic [11:0] yw_out;
    logic        yw_valid, yw_ready, yw_err;

    int check_count = 0;
    int pass_count  = 0;

`ifdef FIR_SAT_EN
    localparam int EXP_W = 4095;
`else
    localparam int EXP_W = 519;
`endif

    always #5 clk = ~clk;

    fir_symmetric_param #(.DW(8), .CW(8), .NTAPS(7), .OW(19)) u_fir7 (
        .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid),
        .coef_val(coef_val), .writeen(we7), .tlast(tlast),
        .y_out(y7_out), .y_valid(y7_valid), .coeffs_ready(y7_ready), .coef_err(y7_err)
    );

    fir_symmetric_param #(.DW(8), .CW(8), .NTAPS(6), .OW(19)) u_fir6 (
        .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid),
        .coef_val(coef_val), .writeen(we6), .tlast(tlast),
        .y_out(y6_out), .y_valid(y6_valid), .coeffs_ready(y6_ready), .coef_err(y6_err)
    );

    fir_symmetric_param #(.DW(8), .CW(8), .NTAPS(7), .OW(12)) u_firw (
        .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid),
        .coef_val(coef_val), .writeen(wew), .tlast(tlast),
        .y_out(yw_out), .y_valid(yw_valid), .coeffs_ready(yw_ready), .coef_err(yw_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [7:0] x, input logic v);
        @(negedge clk);
        x_in    = x;
        x_valid = v;
        @(posedge clk);
        #1;
    endtask

    // sel bit 0 targets the 7-tap, bit 1 the 6-tap, bit 2 the narrow instance.
    task automatic writeWord(input logic [2:0] sel, input logic [7:0] val, input logic last);
        @(negedge clk);
        x_valid  = 1'b0;
        coef_val = val;
        tlast    = last;
        {wew, we6, we7} = sel;
        @(posedge clk);
        #1;
        {wew, we6, we7} = 3'b000;
        tlast = 1'b0;
    endtask

    task automatic runImpulse();
        int e7[7] = '{1, 2, 3, 4, 3, 2, 1};
        int e6[6] = '{1, 2, 3, 3, 2, 1};
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i == 0) ? 8'd1 : 8'd0, 1'b1);
            if (i >= 3) begin
                checkOutput("imp7_valid", 32'(y7_valid), 32'd1);
                checkOutput("imp7_y", 32'(y7_out), 32'(e7[i-3]));
                if (i < 9) begin
                    checkOutput("imp6_y", 32'(y6_out), 32'(e6[i-3]));
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'd0, 1'b0);
        end
        checkOutput("imp7_drain_valid", 32'(y7_valid), 32'd0);
    endtask

    initial begin
        $display("[TB] start");
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_y", 32'(y7_out), 32'd0);
        checkOutput("rst_valid", 32'(y7_valid), 32'd0);
        checkOutput("rst_ready", 32'(y7_ready), 32'd0);
        checkOutput("rst_err", 32'(y7_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        writeWord(3'b001, 8'd1, 1'b0);
        writeWord(3'b001, 8'd2, 1'b0);
        writeWord(3'b001, 8'd3, 1'b0);
        writeWord(3'b001, 8'd4, 1'b1);
        checkOutput("load7_ready", 32'(y7_ready), 32'd1);
        checkOutput("load7_err", 32'(y7_err), 32'd0);

        writeWord(3'b010, 8'd1, 1'b0);
        writeWord(3'b010, 8'd2, 1'b0);
        writeWord(3'b010, 8'd3, 1'b1);
        checkOutput("load6_ready", 32'(y6_ready), 32'd1);

        writeWord(3'b100, 8'd255, 1'b0);
        writeWord(3'b100, 8'd255, 1'b0);
        writeWord(3'b100, 8'd255, 1'b0);
        writeWord(3'b100, 8'd255, 1'b1);
        checkOutput("loadw_ready", 32'(yw_ready), 32'd1);

        runImpulse();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'd255, 1'b1);
        end
        checkOutput("steady7_y", 32'(y7_out), 32'd4080);
        checkOutput("steady6_y", 32'(y6_out), 32'd3060);
        checkOutput("width_y", 32'(yw_out), 32'(EXP_W));
        checkOutput("width_valid", 32'(yw_valid), 32'd1);

        applyStimulus(8'd255, 1'b0);
        applyStimulus(8'd255, 1'b0);
        applyStimulus(8'd255, 1'b1);
        applyStimulus(8'd255, 1'b1);
        checkOutput("gap1_valid", 32'(y7_valid), 32'd0);
        checkOutput("gap1_y", 32'(y7_out), 32'd4080);
        applyStimulus(8'd255, 1'b1);
        checkOutput("gap2_valid", 32'(y7_valid), 32'd0);
        checkOutput("gap2_y", 32'(y7_out), 32'd4080);
        applyStimulus(8'd255, 1'b1);
        checkOutput("gap_end_valid", 32'(y7_valid), 32'd1);
        checkOutput("gap_end_y", 32'(y7_out), 32'd4080);

        writeWord(3'b001, 8'd5, 1'b0);
        checkOutput("bad_first_ready", 32'(y7_ready), 32'd0);
        writeWord(3'b001, 8'd6, 1'b0);
        writeWord(3'b001, 8'd7, 1'b1);
        checkOutput("bad_err", 32'(y7_err), 32'd1);
        checkOutput("bad_ready", 32'(y7_ready), 32'd0);
        applyStimulus(8'd255, 1'b1);
        checkOutput("bad_err_pulse", 32'(y7_err), 32'd0);
        checkOutput("bad_valid0", 32'(y7_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'd255, 1'b1);
            checkOutput("bad_valid", 32'(y7_valid), 32'd0);
        end

        writeWord(3'b001, 8'd1, 1'b0);
        writeWord(3'b001, 8'd2, 1'b0);
        writeWord(3'b001, 8'd3, 1'b0);
        writeWord(3'b001, 8'd4, 1'b1);
        checkOutput("good_ready", 32'(y7_ready), 32'd1);
        checkOutput("good_err", 32'(y7_err), 32'd0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'd255, 1'b1);
        end
        checkOutput("restore_y", 32'(y7_out), 32'd4080);
        checkOutput("restore_valid", 32'(y7_valid), 32'd1);

        applyStimulus(8'd255, 1'b1);
        #2;
        rst     = 1'b1;
        x_valid = 1'b0;
        #1;
        checkOutput("midrst_y", 32'(y7_out), 32'd0);
        checkOutput("midrst_valid", 32'(y7_valid), 32'd0);
        checkOutput("midrst_ready", 32'(y7_ready), 32'd0);
        checkOutput("midrst_err", 32'(y7_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        writeWord(3'b001, 8'd1, 1'b0);
        writeWord(3'b001, 8'd2, 1'b0);
        writeWord(3'b001, 8'd3, 1'b0);
        writeWord(3'b001, 8'd4, 1'b1);
        checkOutput("reload7_ready", 32'(y7_ready), 32'd1);
        writeWord(3'b010, 8'd1, 1'b0);
        writeWord(3'b010, 8'd2, 1'b0);
        writeWord(3'b010, 8'd3, 1'b1);
        checkOutput("reload6_ready", 32'(y6_ready), 32'd1);
        runImpulse();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
